game_sequencer: RTL and testbench

Top-level scheduler for the rhythm game: owns the game state machine, generates the metronome beat and hit window, picks the arrow for each beat, and consumes the collision checker's correct/incorrect hit flags to keep score and lives. It drives the `state`, `metronome_clk` and `arrow` inputs of the collision checker and feeds the score display.

---
 rtl/game_sequencer_pkg.sv | 34 +++
 rtl/game_sequencer_arrow_lfsr.sv | 25 ++
 rtl/game_sequencer.sv | 168 ++++++++++++++++
 tb/tb_game_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Constants shared by the rhythm-game sequencer and the collision checker:
// state codes, arrow codes and the arrow LFSR helpers.
package game_sequencer_pkg;

  localparam int unsigned STATE_BITS      = 2;
  localparam int unsigned NUM_ARROWS_BITS = 5;
  localparam int unsigned RANDOM_BITS     = 6;

  typedef enum logic [STATE_BITS-1:0] {
    ST_GAME  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RESET = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // Playable arrows are 10..19; 20 means no arrow on screen.
  localparam logic [NUM_ARROWS_BITS-1:0] ARROW_FIRST = 5'd10;
  localparam logic [NUM_ARROWS_BITS-1:0] ARROW_LAST  = 5'd19;
  localparam logic [NUM_ARROWS_BITS-1:0] ARROW_NONE  = 5'd20;

  localparam logic [RANDOM_BITS-1:0] LFSR_SEED = 6'b000001;

  // Fibonacci LFSR, polynomial x^6 + x^5 + 1.
  function automatic logic [RANDOM_BITS-1:0] lfsr_next(input logic [RANDOM_BITS-1:0] r);
    return {r[4:0], r[5] ^ r[4]};
  endfunction

  function automatic logic [NUM_ARROWS_BITS-1:0] random_to_arrow(input logic [RANDOM_BITS-1:0] r);
    logic [RANDOM_BITS-1:0] m;
    m = r % 6'd10;
    return ARROW_FIRST + NUM_ARROWS_BITS'(m);
  endfunction

endpackage

// File: rtl/game_sequencer_arrow_lfsr.sv
// Free-running arrow generator: 6-bit LFSR stepping every clock, mapped
// to an arrow code in 10..19.
module arrow_lfsr
  import game_sequencer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  output logic [NUM_ARROWS_BITS-1:0] arrow_code
);

  logic [RANDOM_BITS-1:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    arrow_code = random_to_arrow(lfsr_q);
  end

endmodule

// File: rtl/game_sequencer.sv
// Rhythm-game scheduler: game FSM, beat counter / hit window, arrow
// selection and score/lives bookkeeping from the collision checker flags.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES   = 50_000_000,
  parameter int unsigned WINDOW_CYCLES = 30_000_000,
  parameter int unsigned GUARD_CYCLES  = 4,
  parameter int unsigned START_LIVES   = 5,
  parameter int unsigned SCORE_MAX     = 9999
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_req,
  input  logic                       pause_req,
  input  logic                       correct_hit,
  input  logic                       incorrect_hit,
  output logic [STATE_BITS-1:0]      state,
  output logic                       metronome_clk,
  output logic [NUM_ARROWS_BITS-1:0] arrow,
  output logic [13:0]                score,
  output logic [3:0]                 lives,
  output logic                       beat_tick
);

  localparam int unsigned CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_WIN  = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] CNT_GRD  = CNT_W'(GUARD_CYCLES);
  localparam logic [13:0]      SCORE_SAT  = 14'(SCORE_MAX);
  localparam logic [3:0]       LIVES_INIT = 4'(START_LIVES);

  game_state_t                state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d, count_inc;
  logic                       metro_q, metro_d;
  logic [NUM_ARROWS_BITS-1:0] arrow_q, arrow_d;
  logic [13:0]                score_q, score_d;
  logic [3:0]                 lives_q, lives_d;
  logic                       tick_q, tick_d;
  logic                       judged_q, judged_d;
  logic [NUM_ARROWS_BITS-1:0] lfsr_arrow;

  arrow_lfsr u_arrow_lfsr (
    .clk        (clk),
    .rst        (rst),
    .arrow_code (lfsr_arrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RESET;
      count_q  <= '0;
      metro_q  <= 1'b0;
      arrow_q  <= ARROW_NONE;
      score_q  <= '0;
      lives_q  <= LIVES_INIT;
      tick_q   <= 1'b0;
      judged_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      metro_q  <= metro_d;
      arrow_q  <= arrow_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      tick_q   <= tick_d;
      judged_q <= judged_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    metro_d   = metro_q;
    arrow_d   = arrow_q;
    score_d   = score_q;
    lives_d   = lives_q;
    judged_d  = judged_q;
    tick_d    = 1'b0;
    count_inc = count_q + 1'b1;

    case (state_q)
      ST_RESET: begin
        count_d  = '0;
        metro_d  = 1'b0;
        arrow_d  = ARROW_NONE;
        score_d  = '0;
        lives_d  = LIVES_INIT;
        judged_d = 1'b0;
        if (start_req) begin
          state_d = ST_GAME;
          metro_d = 1'b1;
          arrow_d = lfsr_arrow;
          tick_d  = 1'b1;
        end
      end

      ST_GAME: begin
        if (pause_req) begin
          state_d = ST_PAUSE;
        end else begin
          // Judge against the count sampled this edge; a wrap on the same
          // edge then clears judged for the new beat.
          if (count_q >= CNT_GRD && !judged_q) begin
            if (correct_hit) begin
              if (score_q < SCORE_SAT) begin
                score_d = score_q + 1'b1;
              end
              judged_d = 1'b1;
            end else if (incorrect_hit) begin
              lives_d  = lives_q - 1'b1;
              judged_d = 1'b1;
            end
          end

          if (count_q == CNT_LAST) begin
            count_d  = '0;
            metro_d  = 1'b1;
            arrow_d  = lfsr_arrow;
            tick_d   = 1'b1;
            judged_d = 1'b0;
          end else begin
            count_d = count_inc;
            metro_d = (count_inc < CNT_WIN);
          end

          // Losing the last life overrides any beat-start update on this edge.
          if (lives_q == 4'd1 && lives_d == 4'd0) begin
            state_d = ST_OVER;
            metro_d = 1'b0;
            arrow_d = ARROW_NONE;
            tick_d  = 1'b0;
          end
        end
      end

      ST_PAUSE: begin
        if (pause_req) begin
          state_d = ST_GAME;
        end
      end

      ST_OVER: begin
        if (start_req) begin
          state_d  = ST_RESET;
          count_d  = '0;
          metro_d  = 1'b0;
          arrow_d  = ARROW_NONE;
          score_d  = '0;
          lives_d  = LIVES_INIT;
          judged_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign state         = state_q;
  assign metronome_clk = metro_q;
  assign arrow         = arrow_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign beat_tick     = tick_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: beat/window timing, arrow selection,
// hit judgement, pause, game over, async reset and score saturation.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_req = 1'b0, pause_req = 1'b0, correct_hit = 1'b0, incorrect_hit = 1'b0;
  logic [1:0]  state;
  logic        metronome_clk, beat_tick;
  logic [4:0]  arrow;
  logic [13:0] score;
  logic [3:0]  lives;

  logic s_start = 1'b0, s_pause = 1'b0, s_correct = 1'b0, s_incorrect = 1'b0;
  logic [1:0]  s_state;
  logic        s_metro, s_tick;
  logic [4:0]  s_arrow;
  logic [13:0] s_score;
  logic [3:0]  s_lives;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [5:0]  lfsr_m;
  logic [5:0]  prev_lfsr;
  int          cnt = 0;
  logic [4:0]  exp_arrow = 5'd20;

  always #5 clk = ~clk;

  game_sequencer #(
    .BEAT_CYCLES(16), .WINDOW_CYCLES(10), .GUARD_CYCLES(4),
    .START_LIVES(5), .SCORE_MAX(9999)
  ) dut (
    .clk(clk), .rst(rst), .start_req(start_req), .pause_req(pause_req),
    .correct_hit(correct_hit), .incorrect_hit(incorrect_hit),
    .state(state), .metronome_clk(metronome_clk), .arrow(arrow),
    .score(score), .lives(lives), .beat_tick(beat_tick)
  );

  game_sequencer #(
    .BEAT_CYCLES(8), .WINDOW_CYCLES(5), .GUARD_CYCLES(4),
    .START_LIVES(2), .SCORE_MAX(3)
  ) dut_sat (
    .clk(clk), .rst(rst), .start_req(s_start), .pause_req(s_pause),
    .correct_hit(s_correct), .incorrect_hit(s_incorrect),
    .state(s_state), .metronome_clk(s_metro), .arrow(s_arrow),
    .score(s_score), .lives(s_lives), .beat_tick(s_tick)
  );

  // Reference LFSR, x^6 + x^5 + 1, seed 1.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 6'b000001;
    else     lfsr_m <= {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[4]};
  end

  // prev_lfsr ends up holding the LFSR value the DUT saw on the edge just crossed.
  task automatic tick();
    prev_lfsr = lfsr_m;
    @(negedge clk);
  endtask

  task automatic adv();
    tick();
    cnt = (cnt == 15) ? 0 : cnt + 1;
    if (cnt == 0) exp_arrow = 5'd10 + 5'(prev_lfsr % 6'd10);
  endtask

  task automatic adv_to(input int target);
    for (int i = 0; i < 17 && cnt != target; i++) adv();
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL reset_state: got %0d want 2", state); end
    total++; if (metronome_clk !== 1'b0) begin bad++; $display("FAIL reset_metro: got %b want 0", metronome_clk); end
    total++; if (arrow !== 5'd20) begin bad++; $display("FAIL reset_arrow: got %0d want 20", arrow); end
    total++; if (score !== 14'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    total++; if (lives !== 4'd5) begin bad++; $display("FAIL reset_lives: got %0d want 5", lives); end
    total++; if (beat_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", beat_tick); end
    total++; if (s_lives !== 4'd2) begin bad++; $display("FAIL reset_lives2: got %0d want 2", s_lives); end
    rst = 1'b0;
    tick(); tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL idle_state: got %0d want 2", state); end
  endtask

  task automatic test_beat();
    start_req = 1'b1; tick(); start_req = 1'b0;
    cnt = 0; exp_arrow = 5'd10 + 5'(prev_lfsr % 6'd10);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL start_state: got %0d want 0", state); end
    total++; if (metronome_clk !== 1'b1) begin bad++; $display("FAIL start_metro: got %b want 1", metronome_clk); end
    total++; if (beat_tick !== 1'b1) begin bad++; $display("FAIL start_tick: got %b want 1", beat_tick); end
    total++; if (arrow !== exp_arrow) begin bad++; $display("FAIL start_arrow: got %0d want %0d", arrow, exp_arrow); end
    for (int i = 0; i < 32; i++) begin
      adv();
      total++; if (metronome_clk !== (cnt < 10)) begin bad++; $display("FAIL beat_metro: cnt %0d got %b want %b", cnt, metronome_clk, cnt < 10); end
      total++; if (beat_tick !== (cnt == 0)) begin bad++; $display("FAIL beat_tick: cnt %0d got %b want %b", cnt, beat_tick, cnt == 0); end
      total++; if (arrow !== exp_arrow || arrow < 5'd10 || arrow > 5'd19) begin bad++; $display("FAIL beat_arrow: cnt %0d got %0d want %0d", cnt, arrow, exp_arrow); end
    end
    total++; if (score !== 14'd0 || lives !== 4'd5) begin bad++; $display("FAIL beat_idle_score: got %0d/%0d want 0/5", score, lives); end
  endtask

  task automatic test_correct_hold();
    adv_to(5);
    correct_hit = 1'b1;
    adv();
    total++; if (score !== 14'd1) begin bad++; $display("FAIL hold_first: got %0d want 1", score); end
    adv_to(3);
    correct_hit = 1'b0;
    total++; if (score !== 14'd1) begin bad++; $display("FAIL hold_once: got %0d want 1", score); end
    total++; if (lives !== 4'd5) begin bad++; $display("FAIL hold_lives: got %0d want 5", lives); end
  endtask

  task automatic test_both();
    adv_to(6);
    correct_hit = 1'b1; incorrect_hit = 1'b1;
    adv();
    correct_hit = 1'b0; incorrect_hit = 1'b0;
    total++; if (score !== 14'd2) begin bad++; $display("FAIL both_score: got %0d want 2", score); end
    total++; if (lives !== 4'd5) begin bad++; $display("FAIL both_lives: got %0d want 5", lives); end
  endtask

  task automatic test_pause();
    adv_to(0); adv_to(7);
    pause_req = 1'b1; tick(); pause_req = 1'b0;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL pause_state: got %0d want 1", state); end
    correct_hit = 1'b1; incorrect_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (state !== 2'd1 || metronome_clk !== 1'b1 || arrow !== exp_arrow || beat_tick !== 1'b0)
        begin bad++; $display("FAIL pause_frozen: got st %0d m %b a %0d t %b want 1 1 %0d 0", state, metronome_clk, arrow, beat_tick, exp_arrow); end
      total++; if (score !== 14'd2 || lives !== 4'd5) begin bad++; $display("FAIL pause_hits: got %0d/%0d want 2/5", score, lives); end
    end
    correct_hit = 1'b0; incorrect_hit = 1'b0;
    pause_req = 1'b1; tick(); pause_req = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL resume_state: got %0d want 0", state); end
    for (int i = 0; i < 9; i++) begin
      adv();
      total++; if (beat_tick !== (cnt == 0) || metronome_clk !== (cnt < 10))
        begin bad++; $display("FAIL resume_count: cnt %0d got t %b m %b", cnt, beat_tick, metronome_clk); end
    end
  endtask

  task automatic test_lives();
    for (int i = 1; i <= 5; i++) begin
      adv_to(5);
      incorrect_hit = 1'b1;
      if (i < 5) adv(); else tick();
      incorrect_hit = 1'b0;
      total++; if (lives !== 4'(5 - i)) begin bad++; $display("FAIL lives_step: got %0d want %0d", lives, 5 - i); end
    end
    total++; if (state !== 2'd3) begin bad++; $display("FAIL over_state: got %0d want 3", state); end
    total++; if (arrow !== 5'd20 || metronome_clk !== 1'b0) begin bad++; $display("FAIL over_outputs: got a %0d m %b want 20 0", arrow, metronome_clk); end
    correct_hit = 1'b1;
    pause_req = 1'b1; tick(); pause_req = 1'b0;
    tick(); tick();
    correct_hit = 1'b0;
    total++; if (state !== 2'd3 || score !== 14'd2 || lives !== 4'd0)
      begin bad++; $display("FAIL over_hold: got st %0d sc %0d lv %0d want 3 2 0", state, score, lives); end
    start_req = 1'b1; tick(); start_req = 1'b0;
    total++; if (state !== 2'd2 || score !== 14'd0 || lives !== 4'd5)
      begin bad++; $display("FAIL over_restart: got st %0d sc %0d lv %0d want 2 0 5", state, score, lives); end
    pause_req = 1'b1; tick(); pause_req = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL reset_pause_ignored: got %0d want 2", state); end
  endtask

  task automatic test_rst_mid();
    start_req = 1'b1; tick(); start_req = 1'b0;
    cnt = 0; exp_arrow = 5'd10 + 5'(prev_lfsr % 6'd10);
    adv_to(3);
    rst = 1'b1;
    #1;
    total++; if (state !== 2'd2 || metronome_clk !== 1'b0 || arrow !== 5'd20 || score !== 14'd0 || lives !== 4'd5 || beat_tick !== 1'b0)
      begin bad++; $display("FAIL rst_mid: got st %0d m %b a %0d sc %0d lv %0d t %b", state, metronome_clk, arrow, score, lives, beat_tick); end
    #1 rst = 1'b0;
    tick();
    start_req = 1'b1; tick(); start_req = 1'b0;
    total++; if (arrow !== 5'd12) begin bad++; $display("FAIL rst_reseed: got %0d want 12", arrow); end
  endtask

  task automatic test_saturate();
    int c2;
    int hits;
    s_start = 1'b1; tick(); s_start = 1'b0;
    total++; if (s_state !== 2'd0 || s_metro !== 1'b1 || s_tick !== 1'b1)
      begin bad++; $display("FAIL sat_start: got st %0d m %b t %b want 0 1 1", s_state, s_metro, s_tick); end
    s_correct = 1'b1;
    c2 = 0; hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (c2 == 4) hits++;
      c2 = (c2 + 1) % 8;
      total++; if (s_score !== 14'((hits > 3) ? 3 : hits))
        begin bad++; $display("FAIL sat_score: step %0d got %0d want %0d", i, s_score, (hits > 3) ? 3 : hits); end
    end
    s_correct = 1'b0;
    total++; if (s_lives !== 4'd2 || s_state !== 2'd0) begin bad++; $display("FAIL sat_lives: got %0d st %0d want 2 0", s_lives, s_state); end
  endtask

  initial begin
    test_reset();
    test_beat();
    test_correct_hold();
    test_both();
    test_pause();
    test_lives();
    test_rst_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
